// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: packet-locked N-input AXI-stream output arbiter with destination filter and 2-entry skid output.
module pkt_rr_arbiter #(
  parameter int N_PORTS  = 4,
  parameter int DATA_W   = 32,
  parameter int DEST_W   = 3,
  parameter int ID       = 0,
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                         clk_line,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           in_TVALID,
  input  logic [N_PORTS*DATA_W-1:0]    in_TDATA,
  input  logic [N_PORTS*DATA_W/8-1:0]  in_TKEEP,
  input  logic [N_PORTS-1:0]           in_TLAST,
  input  logic [N_PORTS*DEST_W-1:0]    in_TDEST,
  output logic [N_PORTS-1:0]           in_TREADY,
  output logic [DATA_W-1:0]            out_TDATA,
  output logic [DATA_W/8-1:0]          out_TKEEP,
  output logic                         out_TLAST,
  output logic                         out_TVALID,
  input  logic                         out_TREADY,
  output logic [N_PORTS-1:0]           grant,
  output logic [CNT_W-1:0]             pkt_cnt
);
  localparam int KW = DATA_W / 8;
  localparam int IW = $clog2(N_PORTS);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [IW-1:0] ptr, w, win;
  logic [N_PORTS-1:0] req;
  logic [DATA_W-1:0] sel_data, skid_data;
  logic [KW-1:0] sel_keep, skid_keep;
  logic sel_last, skid_last, skid_valid, acc, done;
  int s;
  // Scan downward from ptr+N-1 so the first requester at or after ptr wins; fixed mode keeps ptr at 0.
  always_comb begin
    req = '0;
    win = '0;
    s = 0;
    for (int i = 0; i < N_PORTS; i++)
      req[i] = in_TVALID[i] & (in_TDEST[i*DEST_W +: DEST_W] == DEST_W'(ID));
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      s = s >= N_PORTS ? s - N_PORTS : s;
      if (req[IW'(s)]) win = IW'(s);
    end
  end
  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_PORTS; i++)
      if (grant[i]) begin
        sel_data = in_TDATA[i*DATA_W +: DATA_W];
        sel_keep = in_TKEEP[i*KW +: KW];
        sel_last = in_TLAST[i];
      end
  end
  assign in_TREADY = grant & {N_PORTS{~skid_valid}};
  assign acc = |(in_TVALID & in_TREADY);
  assign done = acc & sel_last;
  always_ff @(posedge clk_line) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      w <= '0;
      grant <= '0;
      pkt_cnt <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= LOCKED;
        w <= win;
        grant <= N_PORTS'(1) << win;
      end
    end else if (done) begin
      state <= IDLE;
      grant <= '0;
      pkt_cnt <= pkt_cnt + 1'b1;
      ptr <= (ARB_MODE != 0) ? '0 : (w == IW'(N_PORTS - 1)) ? '0 : w + 1'b1;
    end
  end
  always_ff @(posedge clk_line) begin
    if (!rst) begin
      out_TVALID <= 1'b0;
      out_TDATA <= '0;
      out_TKEEP <= '0;
      out_TLAST <= 1'b0;
      skid_valid <= 1'b0;
      skid_data <= '0;
      skid_keep <= '0;
      skid_last <= 1'b0;
    end else if (out_TREADY || !out_TVALID) begin
      if (skid_valid) begin
        out_TVALID <= 1'b1;
        out_TDATA <= skid_data;
        out_TKEEP <= skid_keep;
        out_TLAST <= skid_last;
        skid_valid <= 1'b0;
      end else begin
        out_TVALID <= acc;
        if (acc) begin
          out_TDATA <= sel_data;
          out_TKEEP <= sel_keep;
          out_TLAST <= sel_last;
        end
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data <= sel_data;
      skid_keep <= sel_keep;
      skid_last <= sel_last;
    end
  end
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// tb_pkt_rr_arbiter: directed stimulus with scoreboard queues for output beats and grant order.
module tb_pkt_rr_arbiter;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l; logic [2:0] t;} beat_t;
  logic clk_line = 1'b0;
  logic rst = 1'b0;
  always #5 clk_line = ~clk_line;
  logic [3:0] in_TVALID = '0, in_TLAST = '0, in_TREADY, grant;
  logic [127:0] in_TDATA = '0;
  logic [15:0] in_TKEEP = '0;
  logic [11:0] in_TDEST = '0;
  logic [31:0] out_TDATA;
  logic [3:0] out_TKEEP;
  logic out_TLAST, out_TVALID;
  logic out_TREADY = 1'b1;
  logic [1:0] pkt_cnt;
  logic [3:0] fx_tready, fx_grant, fx_keep;
  logic [31:0] fx_data;
  logic fx_last, fx_valid;
  logic [15:0] fx_cnt;
  int total = 0, bad = 0, cyc = 0, out_n = 0, fx3 = 0;
  int hs_cnt[4] = '{0, 0, 0, 0};
  beat_t src_q[4][$];
  beat_t exp_q[$];
  logic [3:0] exp_g[$];
  int out_cyc[$];
  logic hold = 1'b0, hl;
  logic [31:0] hd;
  logic [3:0] hk, pg = '0;

  pkt_rr_arbiter #(.N_PORTS(4), .DATA_W(32), .DEST_W(3), .ID(2), .ARB_MODE(0), .CNT_W(2)) dut (
    .clk_line(clk_line), .rst(rst), .in_TVALID(in_TVALID), .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP),
    .in_TLAST(in_TLAST), .in_TDEST(in_TDEST), .in_TREADY(in_TREADY), .out_TDATA(out_TDATA),
    .out_TKEEP(out_TKEEP), .out_TLAST(out_TLAST), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
    .grant(grant), .pkt_cnt(pkt_cnt));

  // Ports 0 and 3 request continuously with single-beat packets.
  pkt_rr_arbiter #(.N_PORTS(4), .DATA_W(32), .DEST_W(3), .ID(2), .ARB_MODE(1), .CNT_W(16)) fx (
    .clk_line(clk_line), .rst(rst), .in_TVALID(4'b1001), .in_TDATA({4{32'h5A5A_0000}}), .in_TKEEP(16'hFFFF),
    .in_TLAST(4'b1111), .in_TDEST({4{3'd2}}), .in_TREADY(fx_tready), .out_TDATA(fx_data),
    .out_TKEEP(fx_keep), .out_TLAST(fx_last), .out_TVALID(fx_valid), .out_TREADY(1'b1),
    .grant(fx_grant), .pkt_cnt(fx_cnt));

  always @(posedge clk_line) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic at_pos();
    @(posedge clk_line);
    #2;
  endtask

  task automatic send(input int p, input int n, input logic [31:0] base, input logic [2:0] dst, input bit expect_out);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt.d = base + 32'(b);
      bt.k = (b == n - 1) ? 4'h3 : 4'hF;
      bt.l = (b == n - 1);
      bt.t = dst;
      src_q[p].push_back(bt);
      if (expect_out) exp_q.push_back(bt);
    end
  endtask

  task automatic wait_out(input int target, input int budget);
    int c = 0;
    while (out_n < target && c < budget) begin
      @(negedge clk_line);
      c++;
    end
    if (out_n < target) begin
      total++;
      bad++;
      $display("FAIL wait_out: got %0d beats expected %0d", out_n, target);
    end
  endtask

  task automatic do_reset();
    at_pos();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    at_pos();
    at_pos();
    rst = 1'b1;
  endtask

  // Source model: drop the front beat after a handshake, then present the next one.
  initial begin
    logic [3:0] hs;
    forever begin
      @(negedge clk_line);
      hs = in_TVALID & in_TREADY;
      @(posedge clk_line);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          in_TVALID[i] = 1'b1;
          in_TDATA[i*32 +: 32] = src_q[i][0].d;
          in_TKEEP[i*4 +: 4] = src_q[i][0].k;
          in_TLAST[i] = src_q[i][0].l;
          in_TDEST[i*3 +: 3] = src_q[i][0].t;
        end else in_TVALID[i] = 1'b0;
      end
    end
  end

  initial begin
    beat_t e;
    forever begin
      @(negedge clk_line);
      for (int i = 0; i < 4; i++) if ((in_TVALID[i] & in_TREADY[i]) === 1'b1) hs_cnt[i]++;
      if (rst) begin
        if (hold) begin
          chk("hold_valid", out_TVALID, 1);
          chk("hold_data", out_TDATA, hd);
          chk("hold_keep", out_TKEEP, hk);
          chk("hold_last", out_TLAST, hl);
        end
        if (out_TVALID && out_TREADY) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %0h expected none", out_TDATA);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", out_TDATA, e.d);
            chk("beat_keep", out_TKEEP, e.k);
            chk("beat_last", out_TLAST, e.l);
          end
          out_cyc.push_back(cyc);
          out_n++;
        end
        if (grant != 0 && pg == 0) begin
          if (exp_g.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_grant: got %b expected none", grant);
          end else chk("grant", grant, exp_g.pop_front());
        end
        if (fx_grant != 0) chk("fx_grant", fx_grant, 4'b0001);
        if (fx_grant[3]) fx3++;
        hold = out_TVALID & ~out_TREADY;
        hd = out_TDATA;
        hk = out_TKEEP;
        hl = out_TLAST;
        pg = grant;
      end else begin
        hold = 1'b0;
        pg = '0;
      end
    end
  end

  initial begin
    int base, t0, n0, c, acc, low_at, r, v, h0;
    repeat (3) at_pos();
    @(negedge clk_line);
    chk("rst_grant", grant, 0);
    chk("rst_tready", in_TREADY, 0);
    chk("rst_tvalid", out_TVALID, 0);
    chk("rst_tdata", out_TDATA, 0);
    chk("rst_tkeep", out_TKEEP, 0);
    chk("rst_tlast", out_TLAST, 0);
    chk("rst_cnt", pkt_cnt, 0);
    at_pos();
    rst = 1'b1;
    // Single 3-beat packet from port 1.
    @(negedge clk_line);
    base = out_cyc.size();
    n0 = out_n;
    exp_g.push_back(4'b0010);
    send(1, 3, 32'hA0, 3'd2, 1);
    c = 0;
    while (!in_TVALID[1] && c < 10) begin
      @(negedge clk_line);
      c++;
    end
    t0 = cyc;
    wait_out(n0 + 3, 20);
    for (int i = 0; i < 3; i++)
      if (out_cyc.size() > base + i) chk("single_latency", out_cyc[base+i], t0 + 2 + i);
    repeat (2) at_pos();
    @(negedge clk_line);
    chk("single_cnt", pkt_cnt, 1);
    // Destination filter: port 2 addresses another output.
    send(2, 2, 32'hD0, 3'd5, 0);
    r = 0;
    v = 0;
    repeat (8) begin
      @(negedge clk_line);
      r += int'(in_TREADY[2]);
      v += int'(out_TVALID);
    end
    chk("filter_tready", r, 0);
    chk("filter_tvalid", v, 0);
    chk("filter_grant", grant, 0);
    src_q[2].delete();
    repeat (2) @(negedge clk_line);
    // Back-pressure for 5 cycles in the middle of a 10-beat packet.
    n0 = out_n;
    exp_g.push_back(4'b0001);
    send(0, 10, 32'hB0, 3'd2, 1);
    wait_out(n0 + 3, 20);
    at_pos();
    out_TREADY = 1'b0;
    acc = 0;
    low_at = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_line);
      if (in_TVALID[0] && in_TREADY[0]) acc++;
      if (low_at < 0 && !in_TREADY[0]) low_at = i;
    end
    at_pos();
    out_TREADY = 1'b1;
    chk("bp_acc_max2", acc <= 2, 1);
    chk("bp_acc_min1", acc >= 1, 1);
    chk("bp_ready_drop", low_at >= 0 && low_at <= 2, 1);
    wait_out(n0 + 10, 40);
    repeat (2) @(negedge clk_line);
    chk("bp_cnt", pkt_cnt, 2);
    // Round-robin fairness from ptr 0 with 2-beat packets on all ports.
    do_reset();
    @(negedge clk_line);
    n0 = out_n;
    for (int pk = 0; pk < 2; pk++)
      for (int p = 0; p < 4; p++) begin
        exp_g.push_back(4'(1 << p));
        send(p, 2, 32'hC000 + 32'(p * 16 + pk * 4), 3'd2, 1);
      end
    wait_out(n0 + 16, 100);
    repeat (3) @(negedge clk_line);
    chk("rr_cnt_wrap8", pkt_cnt, 0);
    // Reset two beats into a stalled packet.
    at_pos();
    out_TREADY = 1'b0;
    @(negedge clk_line);
    exp_g.push_back(4'b0010);
    h0 = hs_cnt[1];
    send(1, 4, 32'hE0, 3'd2, 0);
    c = 0;
    while (hs_cnt[1] < h0 + 2 && c < 20) begin
      @(negedge clk_line);
      c++;
    end
    chk("mid_beats_in", hs_cnt[1] - h0, 2);
    at_pos();
    rst = 1'b0;
    src_q[1].delete();
    at_pos();
    @(negedge clk_line);
    chk("mid_tvalid", out_TVALID, 0);
    chk("mid_tdata", out_TDATA, 0);
    chk("mid_tkeep", out_TKEEP, 0);
    chk("mid_tlast", out_TLAST, 0);
    chk("mid_grant", grant, 0);
    chk("mid_tready", in_TREADY, 0);
    chk("mid_cnt", pkt_cnt, 0);
    at_pos();
    rst = 1'b1;
    out_TREADY = 1'b1;
    // Fresh packet then four single-beat packets: 5 packets wrap a 2-bit counter to 1.
    @(negedge clk_line);
    n0 = out_n;
    exp_g.push_back(4'b1000);
    send(3, 2, 32'hF0, 3'd2, 1);
    for (int j = 0; j < 4; j++) begin
      exp_g.push_back(4'b1000);
      send(3, 1, 32'hF8 + 32'(j), 3'd2, 1);
    end
    wait_out(n0 + 6, 80);
    repeat (3) @(negedge clk_line);
    chk("wrap5_cnt", pkt_cnt, 1);
    chk("sb_empty", exp_q.size(), 0);
    chk("grant_q_empty", exp_g.size(), 0);
    chk("fx_port3_never", fx3, 0);
    chk("fx_pkts", fx_cnt >= 5, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
